// File: rtl/snn_pkg.sv
// Shared types and default geometry for the SNN layer sequencer and its counter.
package snn_pkg;
   localparam int DEF_TIME_PERIOD = 8;
   localparam int DEF_LOG_TP      = 3;
   localparam int DEF_NUM_SPIKES  = 4;
   localparam int DEF_LOG_NEURONS = 3;
   localparam int DEF_CNT_W       = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      RESULT = 2'd2
   } seq_state_t;

   typedef logic [DEF_LOG_TP:0]      spike_time_t;
   typedef logic [DEF_LOG_NEURONS:0] winner_t;

   // MSB set marks an input (or output) that never spikes in this volley.
   localparam spike_time_t NO_SPIKE = {1'b1, {DEF_LOG_TP{1'b0}}};
endpackage

// File: rtl/snn_time_counter.sv
// Time-step counter for one volley: load clears, enable steps, tc flags the last step.
module snn_time_counter #(
   parameter int W    = 4,
   parameter int LAST = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);
   always_ff @(posedge clk) begin
      if (rst)       cnt <= '0;
      else if (load) cnt <= '0;
      else if (en)   cnt <= cnt + W'(1);
   end

   assign tc = (cnt == W'(LAST));
endmodule

// File: rtl/snn_layer_sequencer.sv
// Runs one volley through an SNN layer for exactly one time period and returns the
// first output spike and winner; one accepted volley at a time, result held until taken.
module snn_layer_sequencer
   import snn_pkg::*;
#(
   parameter int TIME_PERIOD = DEF_TIME_PERIOD,
   parameter int LOG_TP      = DEF_LOG_TP,
   parameter int NUM_SPIKES  = DEF_NUM_SPIKES,
   parameter int LOG_NEURONS = DEF_LOG_NEURONS,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_SPIKES*(LOG_TP+1)-1:0] in_spike_times,
   input  logic                             in_train,
   output logic [LOG_TP:0]                  layer_time_val,
   output logic [NUM_SPIKES*(LOG_TP+1)-1:0] layer_spike_times,
   output logic                             layer_training,
   input  logic [LOG_TP:0]                  layer_out_time,
   input  logic [LOG_NEURONS:0]             layer_winner,
   output logic                             res_valid,
   input  logic                             res_ready,
   output logic [LOG_TP:0]                  res_spike_time,
   output logic [LOG_NEURONS:0]             res_winner,
   output logic                             res_trained,
   output logic [CNT_W-1:0]                 sample_count,
   output logic                             busy
);
   localparam int TW = LOG_TP + 1;
   localparam int SW = NUM_SPIKES * TW;
   localparam logic [LOG_TP:0] TP_LAST      = TW'(TIME_PERIOD - 1);
   localparam logic [SW-1:0]   ALL_NO_SPIKE = {NUM_SPIKES{{1'b1, {LOG_TP{1'b0}}}}};

   seq_state_t        state;
   logic [LOG_TP:0]   cnt;
   logic              cnt_tc;
   logic [SW-1:0]     vol_q;
   logic              train_q;
   logic              captured;
   logic              run;

   assign run = (state == RUN);

   snn_time_counter #(
      .W    (TW),
      .LAST (TIME_PERIOD - 1)
   ) u_time_counter (
      .clk  (clk),
      .rst  (rst),
      .load (state == IDLE),
      .en   (run && !cnt_tc),
      .cnt  (cnt),
      .tc   (cnt_tc)
   );

   // Outside RUN the layer is parked at its last step, which clears its outputs
   // and, with training low, leaves the weights untouched.
   assign layer_time_val    = run ? cnt : TP_LAST;
   assign layer_spike_times = run ? vol_q : ALL_NO_SPIKE;
   assign layer_training    = run && train_q;
   assign res_trained       = train_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         in_ready       <= 1'b1;
         res_valid      <= 1'b0;
         busy           <= 1'b0;
         captured       <= 1'b0;
         train_q        <= 1'b0;
         vol_q          <= ALL_NO_SPIKE;
         sample_count   <= '0;
         res_spike_time <= '1;
         res_winner     <= '1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  vol_q          <= in_spike_times;
                  train_q        <= in_train;
                  captured       <= 1'b0;
                  res_spike_time <= '1;
                  res_winner     <= '1;
                  in_ready       <= 1'b0;
                  busy           <= 1'b1;
                  state          <= RUN;
               end
            end
            RUN: begin
               // Layer output lags one step, so count 0 still shows the parked value.
               if (!captured && (cnt != '0) && !layer_out_time[LOG_TP]) begin
                  res_spike_time <= layer_out_time;
                  res_winner     <= layer_winner;
                  captured       <= 1'b1;
               end
               if (cnt_tc) begin
                  res_valid <= 1'b1;
                  state     <= RESULT;
               end
            end
            RESULT: begin
               if (res_ready) begin
                  sample_count <= sample_count + CNT_W'(1);
                  res_valid    <= 1'b0;
                  in_ready     <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/snn_layer_sequencer.md
Name: snn_layer_sequencer

Overview:
- Controller that sequences one SNN `layer` instance through one volley at a time.
- Accepts a spike-time volley plus a train flag over a valid/ready handshake, drives the layer's time_val, spike_times and training inputs for exactly one time period, captures the layer's first output spike and winner, and returns them over a second valid/ready handshake.
- Sits between the input encoder/testbench stream and the layer. It guarantees exactly one STDP update per training volley and no updates while idle.

Parameters:
- TIME_PERIOD, `time_period, number of time steps per volley (power of two).
- LOG_TP, `log_time_period, time-value width minus one; bit LOG_TP is the "no spike" flag.
- NUM_SPIKES, `num_spikes, inputs per volley.
- LOG_NEURONS, `log_neurons_per_layer, winner index width minus one.
- CNT_W, 16, width of sample counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  volley offered.
- in_ready  out  1  sequencer can accept a volley.
- in_spike_times  in  NUM_SPIKES x (LOG_TP+1)  per-input spike time; MSB=1 means no spike.
- in_train  in  1  apply STDP for this volley.
- layer_time_val  out  LOG_TP+1  to layer time_val.
- layer_spike_times  out  NUM_SPIKES x (LOG_TP+1)  to layer spike_times.
- layer_training  out  1  to layer training.
- layer_out_time  in  LOG_TP+1  from layer output_spike_time.
- layer_winner  in  LOG_NEURONS+1  from layer winning_neuron.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_spike_time  out  LOG_TP+1  captured output time; all-ones = no spike.
- res_winner  out  LOG_NEURONS+1  captured winner; all-ones = none.
- res_trained  out  1  echo of latched in_train.
- sample_count  out  CNT_W  volleys completed (result handshakes).
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, RUN, RESULT. Reset puts the FSM in IDLE, time counter 0, capture flag 0, sample_count 0, res_spike_time and res_winner all-ones, res_trained 0.
- IDLE:
  - in_ready=1.
  - layer_time_val=TIME_PERIOD-1, which parks the layer with its outputs cleared to -1.
  - layer_spike_times all MSB=1 (all inputs invalid).
  - layer_training=0, so no weight change while idle.
  - On in_valid&&in_ready: latch the volley and in_train, clear the capture flag, set res_spike_time/res_winner to all-ones, counter=0, go to RUN.
- RUN:
  - in_ready=0.
  - layer_time_val = counter, which steps 0,1,...,TIME_PERIOD-1, one per cycle.
  - layer_spike_times = latched volley.
  - layer_training = latched train flag, so exactly one STDP evaluation occurs, at counter=TIME_PERIOD-1.
  - At counter=TIME_PERIOD-1 go to RESULT. The counter does not wrap inside RUN.
- Capture rule: the layer output is registered, so the value observed while counter=k reflects time step k-1.
  - In RUN with counter in 1..TIME_PERIOD-1, if the capture flag is 0 and layer_out_time[LOG_TP]==0, latch layer_out_time and layer_winner and set the flag.
  - Ignore later spikes.
  - A spike at time step TIME_PERIOD-1 is never reported; the layer discards it.
- RESULT:
  - res_valid=1, and the result outputs stay stable until the handshake.
  - Layer is driven as in IDLE.
  - On res_ready: sample_count+=1 (wraps modulo 2^CNT_W), go to IDLE.
- Latency: a volley accepted at cycle A gives RUN at A+1..A+TIME_PERIOD and res_valid at A+TIME_PERIOD+1. Minimum spacing between accepts is TIME_PERIOD+2 cycles.
- res_ready held high before RESULT has no effect; there is no combinational in->res path.
- rst mid-RUN or mid-RESULT: the current volley is dropped with no result and the count is not incremented. The layer's own weights are not touched by this block's reset.
- in_valid deasserted or held after handshake: ignored until the next IDLE.

Decomposition:
- Shared package (snn_pkg): state enum {IDLE,RUN,RESULT}, NO_SPIKE constant (MSB set), spike-time typedef (LOG_TP+1 bits), winner typedef.
- One sub-module is natural: snn_time_counter (load/enable/terminal-count flag at TIME_PERIOD-1).

Test Plan (TIME_PERIOD=8, NUM_SPIKES=4):
- Reset then idle 20 cycles -> in_ready=1, layer_time_val=7, layer_training=0, layer_spike_times all MSB=1, sample_count=0.
- Volley {2,3,NO,NO}, train=0, layer stub spikes neuron 5 at step 3 -> res_valid exactly 9 cycles after accept, res_spike_time=3, res_winner=5, res_trained=0, sample_count=1.
- Volley all NO_SPIKE -> res_spike_time=all-ones, res_winner=all-ones; layer_time_val sequence 0..7 observed.
- train=1 volley -> layer_training high only during RUN; exactly one cycle with time_val=7 and training=1; weights of the winner change once.
- res_ready held low 15 cycles in RESULT -> outputs stable, in_ready=0, no new volley accepted; release -> IDLE next cycle.
- Assert rst at counter=4 -> next cycle IDLE, res_valid=0, sample_count unchanged, in_ready=1.
